// File: rtl/mailbox_arb_pkg.sv
// mailbox_arb_pkg
//   Shared definitions for the mailbox slot arbiter: the register offsets
//   decoded from addr[3:2], the slot state encoding, the STATUS word layout
//   and the registered OBI response type.
package mailbox_arb_pkg;

  // Register offsets, addr[3:2]
  localparam logic [1:0] DATA_OFF   = 2'd0;
  localparam logic [1:0] STATUS_OFF = 2'd1;
  localparam logic [1:0] COUNT_OFF  = 2'd2;
  localparam logic [1:0] CLEAR_OFF  = 2'd3;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  // STATUS = {full[31], zeros, src_id[STATUS_SRC_W-1:0]}.
  // The source field is sized for the largest legal writer count (16).
  localparam int unsigned STATUS_FULL_BIT = 31;
  localparam int unsigned STATUS_SRC_W    = 4;

  // One registered response beat (rvalid + rdata).
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } obi_rsp_t;

  function automatic logic [31:0] status_word(input logic                    full,
                                              input logic [STATUS_SRC_W-1:0] src);
    logic [31:0] w;
    w                  = '0;
    w[STATUS_FULL_BIT] = full;
    w[STATUS_SRC_W-1:0] = src;
    return w;
  endfunction

endpackage

// File: rtl/mailbox_rr_arbiter.sv
// mailbox_rr_arbiter
//   Round-robin picker over the eligible writer vector. The grant is purely
//   combinational from eligible_i and the stored pointer; the pointer moves
//   to (granted index + 1) mod NumWriters when advance_i is high and holds
//   otherwise.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset (pointer -> 0)
//   eligible_i    writers that may be granted this cycle
//   advance_i     a grant is being taken this cycle
//   gnt_o         one-hot grant (zero when nothing is eligible)
//   idx_o         index of the granted writer (valid when gnt_o != 0)
module mailbox_rr_arbiter #(
  parameter  int unsigned NumWriters = 4,
  localparam int unsigned IdWidth    = $clog2(NumWriters)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumWriters-1:0] eligible_i,
  input  logic                  advance_i,
  output logic [NumWriters-1:0] gnt_o,
  output logic [IdWidth-1:0]    idx_o
);

  logic [IdWidth-1:0] rr_ptr_q, rr_ptr_d;
  logic               found;

  // Two passes: first the eligible writers at or above the pointer, then
  // wrap to the lowest eligible writer below it. Avoids a modulo on a
  // non-power-of-two writer count.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < NumWriters; i++) begin
      if (!found && eligible_i[i] && (IdWidth'(i) >= rr_ptr_q)) begin
        gnt_o[i] = 1'b1;
        idx_o    = IdWidth'(i);
        found    = 1'b1;
      end
    end
    for (int i = 0; i < NumWriters; i++) begin
      if (!found && eligible_i[i]) begin
        gnt_o[i] = 1'b1;
        idx_o    = IdWidth'(i);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance_i) begin
      rr_ptr_d = (idx_o == IdWidth'(NumWriters - 1)) ? '0 : idx_o + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/mailbox_slot_arbiter.sv
// mailbox_slot_arbiter
//   One single-entry mailbox slot shared by NumWriters OBI writers and one
//   OBI reader. Writers are round-robin arbitrated; the slot remembers which
//   writer filled it. The reader sees DATA / STATUS / COUNT / CLEAR at
//   addr[3:2]; reading DATA drains the slot and bumps COUNT.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   writer_*               NumWriters flattened OBI writer ports (addr and be
//                          are ignored: any writer write fills the slot, any
//                          writer read returns STATUS)
//   reader_*               OBI reader port (be and wdata ignored)
//   full_o                 slot occupied, usable as an interrupt level
// Grants are combinational in the request cycle; responses come one cycle
// later from registers.
module mailbox_slot_arbiter
  import mailbox_arb_pkg::*;
#(
  parameter  int unsigned NumWriters = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned ADDR_WIDTH = 32,
  localparam int unsigned IdWidth    = $clog2(NumWriters)
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NumWriters-1:0]            writer_req_i,
  output logic [NumWriters-1:0]            writer_gnt_o,
  output logic [NumWriters-1:0]            writer_rvalid_o,
  input  logic [NumWriters*ADDR_WIDTH-1:0] writer_addr_i,
  input  logic [NumWriters-1:0]            writer_we_i,
  input  logic [NumWriters*4-1:0]          writer_be_i,
  input  logic [NumWriters*DATA_WIDTH-1:0] writer_wdata_i,
  output logic [NumWriters*DATA_WIDTH-1:0] writer_rdata_o,
  input  logic                             reader_req_i,
  output logic                             reader_gnt_o,
  output logic                             reader_rvalid_o,
  input  logic [ADDR_WIDTH-1:0]            reader_addr_i,
  input  logic                             reader_we_i,
  input  logic [3:0]                       reader_be_i,
  input  logic [DATA_WIDTH-1:0]            reader_wdata_i,
  output logic [DATA_WIDTH-1:0]            reader_rdata_o,
  output logic                             full_o
);

  state_e                              state_q, state_d;
  logic [DATA_WIDTH-1:0]               slot_q, slot_d;
  logic [IdWidth-1:0]                  src_q, src_d;
  logic [31:0]                         count_q, count_d;
  obi_rsp_t [NumWriters-1:0]           w_rsp_q, w_rsp_d;
  obi_rsp_t                            r_rsp_q, r_rsp_d;

  logic [NumWriters-1:0][DATA_WIDTH-1:0] w_wdata;
  logic [NumWriters-1:0]               w_elig, w_gnt;
  logic [IdWidth-1:0]                  w_idx;
  logic                                w_any, w_write;
  logic [1:0]                          r_off;
  logic [31:0]                         status_now;

  assign w_wdata    = writer_wdata_i;
  assign r_off      = reader_addr_i[3:2];
  assign status_now = status_word(state_q == FULL, STATUS_SRC_W'(src_q));

  // Reads are always eligible; writes only into an empty slot, so a write
  // arriving while FULL simply stalls with gnt low until a drain or clear.
  assign w_elig = writer_req_i & ~(writer_we_i & {NumWriters{state_q == FULL}});

  mailbox_rr_arbiter #(
    .NumWriters (NumWriters)
  ) u_rr (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .eligible_i (w_elig),
    .advance_i  (w_any),
    .gnt_o      (w_gnt),
    .idx_o      (w_idx)
  );

  assign w_any        = |w_gnt;
  assign w_write      = w_any & writer_we_i[w_idx];
  assign writer_gnt_o = w_gnt;

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    src_d        = src_q;
    count_d      = count_q;
    w_rsp_d      = '0;
    r_rsp_d      = '0;
    reader_gnt_o = 1'b0;

    // Writer side: at most one grant per cycle.
    if (w_any) begin
      w_rsp_d[w_idx].valid = 1'b1;
      if (w_write) begin
        slot_d  = w_wdata[w_idx];
        src_d   = w_idx;
        state_d = FULL;
      end else begin
        w_rsp_d[w_idx].data = status_now;
      end
    end

    // Reader side. A writer fill only happens in EMPTY and a DATA drain only
    // in FULL, so those two never collide. A CLEAR landing in the same cycle
    // as a fill (slot already EMPTY) yields to the fill so no data is lost.
    if (reader_req_i) begin
      if (reader_we_i) begin
        reader_gnt_o = 1'b1;
        if (r_off == CLEAR_OFF && !w_write) begin
          state_d = EMPTY;
          src_d   = '0;
        end
      end else begin
        case (r_off)
          DATA_OFF: begin
            if (state_q == FULL) begin
              reader_gnt_o = 1'b1;
              r_rsp_d.data = slot_q;
              state_d      = EMPTY;
              count_d      = count_q + 32'd1;
            end
          end
          STATUS_OFF: begin
            reader_gnt_o = 1'b1;
            r_rsp_d.data = status_now;
          end
          COUNT_OFF: begin
            reader_gnt_o = 1'b1;
            r_rsp_d.data = count_q;
          end
          default: begin
            reader_gnt_o = 1'b1;
          end
        endcase
      end
      r_rsp_d.valid = reader_gnt_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      slot_q  <= '0;
      src_q   <= '0;
      count_q <= '0;
      w_rsp_q <= '0;
      r_rsp_q <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      src_q   <= src_d;
      count_q <= count_d;
      w_rsp_q <= w_rsp_d;
      r_rsp_q <= r_rsp_d;
    end
  end

  for (genvar g = 0; g < NumWriters; g++) begin : g_wr_out
    assign writer_rvalid_o[g]                          = w_rsp_q[g].valid;
    assign writer_rdata_o[g*DATA_WIDTH +: DATA_WIDTH] = w_rsp_q[g].data;
  end

  assign reader_rvalid_o = r_rsp_q.valid;
  assign reader_rdata_o  = r_rsp_q.data;
  assign full_o          = (state_q == FULL);

  // Inputs that carry no meaning for this block.
  logic unused_ok;
  assign unused_ok = ^{writer_addr_i, writer_be_i, reader_be_i, reader_wdata_i,
                       reader_addr_i[ADDR_WIDTH-1:4], reader_addr_i[1:0]};

endmodule

// File: tb/tb_mailbox_slot_arbiter.sv
// Directed bench for mailbox_slot_arbiter (4 writers). Inputs change on the
// falling edge; combinational grants are sampled 1 ns later and registered
// responses on the falling edge after the capturing rising edge.
module tb_mailbox_slot_arbiter;
  import mailbox_arb_pkg::*;

  logic         clk_i, rst_i;
  logic [3:0]   writer_req, writer_gnt, writer_rvalid, writer_we;
  logic [127:0] writer_addr, writer_wdata, writer_rdata;
  logic [15:0]  writer_be;
  logic         reader_req, reader_gnt, reader_rvalid, reader_we;
  logic [31:0]  reader_addr, reader_wdata, reader_rdata;
  logic [3:0]   reader_be;
  logic         full_o;

  int n_assert = 0;
  int n_fail   = 0;

  mailbox_slot_arbiter dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .writer_req_i    (writer_req),
    .writer_gnt_o    (writer_gnt),
    .writer_rvalid_o (writer_rvalid),
    .writer_addr_i   (writer_addr),
    .writer_we_i     (writer_we),
    .writer_be_i     (writer_be),
    .writer_wdata_i  (writer_wdata),
    .writer_rdata_o  (writer_rdata),
    .reader_req_i    (reader_req),
    .reader_gnt_o    (reader_gnt),
    .reader_rvalid_o (reader_rvalid),
    .reader_addr_i   (reader_addr),
    .reader_we_i     (reader_we),
    .reader_be_i     (reader_be),
    .reader_wdata_i  (reader_wdata),
    .reader_rdata_o  (reader_rdata),
    .full_o          (full_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required $finish before 200000 ns");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr_set(input int i, input logic req, input logic we, input logic [31:0] d);
    writer_req[i]           = req;
    writer_we[i]            = we;
    writer_wdata[i*32 +: 32] = d;
  endtask

  task automatic rd_req(input logic we, input logic [1:0] off);
    reader_req  = 1'b1;
    reader_we   = we;
    reader_addr = {28'd0, off, 2'b00};
  endtask

  task automatic rd_idle();
    reader_req  = 1'b0;
    reader_we   = 1'b0;
    reader_addr = '0;
  endtask

  // Single reader access that is expected to be granted immediately.
  task automatic reader_access(input string tag, input logic we, input logic [1:0] off,
                               input logic [31:0] exp);
    rd_req(we, off);
    #1;
    check({tag, " rgnt"}, 32'(reader_gnt), 32'd1);
    tick();
    check({tag, " rvalid"}, 32'(reader_rvalid), 32'd1);
    check({tag, " rdata"}, reader_rdata, exp);
    rd_idle();
  endtask

  // Single writer write into an EMPTY slot with no competing writers.
  task automatic writer_write(input string tag, input int i, input logic [31:0] d);
    wr_set(i, 1'b1, 1'b1, d);
    #1;
    check({tag, " wgnt"}, 32'(writer_gnt), 32'd1 << i);
    tick();
    check({tag, " wrvalid"}, 32'(writer_rvalid), 32'd1 << i);
    check({tag, " wrdata"}, writer_rdata[i*32 +: 32], 32'd0);
    check({tag, " full"}, 32'(full_o), 32'd1);
    wr_set(i, 1'b0, 1'b0, 32'd0);
  endtask

  logic [31:0] wdat [4];
  int          order[4];

  initial begin
    wdat  = '{32'h0000_0100, 32'h0000_0101, 32'h0000_0102, 32'h0000_0103};
    order = '{0, 1, 3, 0};
    rst_i = 1'b1;
    writer_req = '0; writer_we = '0; writer_addr = '0; writer_wdata = '0; writer_be = '1;
    reader_be = '1; reader_wdata = 32'hDEAD_BEEF;
    rd_idle();
    @(negedge clk_i);
    tick(); tick();
    rst_i = 1'b0;

    // Reset state
    #1;
    check("rst full", 32'(full_o), 32'd0);
    check("rst wgnt", 32'(writer_gnt), 32'd0);
    check("rst wrvalid", 32'(writer_rvalid), 32'd0);
    check("rst rrvalid", 32'(reader_rvalid), 32'd0);
    tick();
    reader_access("rst status", 1'b0, STATUS_OFF, 32'h0000_0000);
    reader_access("rst count", 1'b0, COUNT_OFF, 32'h0000_0000);

    // Round robin among writers 0,1,3 with a drain after each fill.
    wr_set(0, 1'b1, 1'b1, wdat[0]);
    wr_set(1, 1'b1, 1'b1, wdat[1]);
    wr_set(3, 1'b1, 1'b1, wdat[3]);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr%0d wgnt", k), 32'(writer_gnt), 32'd1 << order[k]);
      tick();
      check($sformatf("rr%0d wrvalid", k), 32'(writer_rvalid), 32'd1 << order[k]);
      check($sformatf("rr%0d full", k), 32'(full_o), 32'd1);
      rd_req(1'b0, DATA_OFF);
      #1;
      check($sformatf("rr%0d drain rgnt", k), 32'(reader_gnt), 32'd1);
      check($sformatf("rr%0d stall wgnt", k), 32'(writer_gnt), 32'd0);
      tick();
      check($sformatf("rr%0d rdata", k), reader_rdata, wdat[order[k]]);
      rd_idle();
    end
    writer_req = '0; writer_we = '0;
    reader_access("rr count", 1'b0, COUNT_OFF, 32'd4);

    // Writer 2 fill, STATUS shows full + src 2, then drain.
    writer_write("w2", 2, 32'hA5A5_0001);
    reader_access("w2 status", 1'b0, STATUS_OFF, 32'h8000_0002);
    reader_access("w2 drain", 1'b0, DATA_OFF, 32'hA5A5_0001);
    check("w2 empty", 32'(full_o), 32'd0);

    // Writer 1 stalls against a FULL slot; a writer read still goes through.
    writer_write("w0 fill", 0, 32'h0000_5A00);
    wr_set(1, 1'b1, 1'b1, 32'h1111_0001);
    for (int c = 0; c < 2; c++) begin
      #1; check($sformatf("stall%0d wgnt", c), 32'(writer_gnt), 32'd0); tick();
    end
    wr_set(3, 1'b1, 1'b0, 32'd0);
    #1; check("w3 read wgnt", 32'(writer_gnt), 32'b1000);
    tick();
    check("w3 read rvalid", 32'(writer_rvalid), 32'b1000);
    check("w3 read rdata", writer_rdata[3*32 +: 32], 32'h8000_0000);
    wr_set(3, 1'b0, 1'b0, 32'd0);
    for (int c = 3; c < 5; c++) begin
      #1; check($sformatf("stall%0d wgnt", c), 32'(writer_gnt), 32'd0); tick();
    end
    rd_req(1'b0, DATA_OFF);
    #1;
    check("stall drain rgnt", 32'(reader_gnt), 32'd1);
    check("stall no same-cycle wgnt", 32'(writer_gnt), 32'd0);
    tick();
    check("stall drain rdata", reader_rdata, 32'h0000_5A00);
    rd_idle();
    #1; check("stall refill wgnt", 32'(writer_gnt), 32'b0010);
    tick();
    check("stall refill full", 32'(full_o), 32'd1);
    wr_set(1, 1'b0, 1'b0, 32'd0);
    reader_access("w1 status", 1'b0, STATUS_OFF, 32'h8000_0001);
    reader_access("w1 drain", 1'b0, DATA_OFF, 32'h1111_0001);

    // Reader DATA read while EMPTY stalls until a writer fills.
    rd_req(1'b0, DATA_OFF);
    for (int c = 0; c < 3; c++) begin
      #1; check($sformatf("empty%0d rgnt", c), 32'(reader_gnt), 32'd0);
      tick();
      check($sformatf("empty%0d rrvalid", c), 32'(reader_rvalid), 32'd0);
    end
    wr_set(0, 1'b1, 1'b1, 32'h0000_1234);
    #1;
    check("empty fill wgnt", 32'(writer_gnt), 32'b0001);
    check("empty fill rgnt", 32'(reader_gnt), 32'd0);
    tick();
    wr_set(0, 1'b0, 1'b0, 32'd0);
    #1; check("empty late rgnt", 32'(reader_gnt), 32'd1);
    tick();
    check("empty late rvalid", 32'(reader_rvalid), 32'd1);
    check("empty late rdata", reader_rdata, 32'h0000_1234);
    rd_idle();
    reader_access("empty count", 1'b0, COUNT_OFF, 32'd8);

    // COUNT wrap 0xFFFFFFFF -> 0.
    force dut.count_q = 32'hFFFF_FFFF;
    #1;
    release dut.count_q;
    writer_write("wrap fill", 3, 32'hCAFE_0003);
    reader_access("wrap drain", 1'b0, DATA_OFF, 32'hCAFE_0003);
    reader_access("wrap count", 1'b0, COUNT_OFF, 32'd0);

    // CLEAR in FULL with writer 2 waiting: write lands the cycle after.
    writer_write("clr fill", 1, 32'hBEEF_0001);
    reader_access("clr pre status", 1'b0, STATUS_OFF, 32'h8000_0001);
    wr_set(2, 1'b1, 1'b1, 32'h2222_0002);
    rd_req(1'b1, CLEAR_OFF);
    #1;
    check("clr rgnt", 32'(reader_gnt), 32'd1);
    check("clr same-cycle wgnt", 32'(writer_gnt), 32'd0);
    tick();
    check("clr rvalid", 32'(reader_rvalid), 32'd1);
    check("clr rdata", reader_rdata, 32'd0);
    check("clr full", 32'(full_o), 32'd0);
    rd_req(1'b0, STATUS_OFF);
    #1;
    check("clr next wgnt", 32'(writer_gnt), 32'b0100);
    check("clr next rgnt", 32'(reader_gnt), 32'd1);
    tick();
    check("fill+status rdata", reader_rdata, 32'h0000_0000);
    check("fill+status full", 32'(full_o), 32'd1);
    check("fill+status wrvalid", 32'(writer_rvalid), 32'b0100);
    rd_idle();
    wr_set(2, 1'b0, 1'b0, 32'd0);
    reader_access("clr post status", 1'b0, STATUS_OFF, 32'h8000_0002);
    reader_access("clr post count", 1'b0, COUNT_OFF, 32'd0);

    // Reset mid-transaction drops the pending response.
    reader_access("pre-rst clear", 1'b1, CLEAR_OFF, 32'd0);
    wr_set(3, 1'b1, 1'b1, 32'h3333_0003);
    #1;
    check("rst grant wgnt", 32'(writer_gnt), 32'b1000);
    rst_i = 1'b1;
    tick();
    check("rst drop wrvalid", 32'(writer_rvalid), 32'd0);
    check("rst drop full", 32'(full_o), 32'd0);
    wr_set(3, 1'b0, 1'b0, 32'd0);
    rst_i = 1'b0;
    reader_access("post-rst status", 1'b0, STATUS_OFF, 32'd0);
    reader_access("post-rst count", 1'b0, COUNT_OFF, 32'd0);
    wr_set(0, 1'b1, 1'b1, 32'h0000_0A0A);
    wr_set(3, 1'b1, 1'b1, 32'h0000_0B0B);
    #1;
    check("post-rst rr wgnt", 32'(writer_gnt), 32'b0001);
    tick();
    writer_req = '0; writer_we = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
